ahb_dmem_slave: RTL and testbench
=================================

// Module: ahb_dmem_slave
// PURPOSE
//  AHB-Lite data-memory responder: the target for the core's store/load path. It takes the
//  word-aligned address, HTRANS and byte write mask from the store unit, commits byte-lane
//  writes, returns read words, and inserts wait states and ERROR responses.
//  Sits between the core's AHB master port and on-chip data RAM.
// PARAMETERS
//  DEPTH_LOG2   10           log2 of RAM depth in 32-bit words (4 KiB default)
//  BASE_ADDR    32'h0001_0000  first byte address decoded by this slave
//  WAIT_STATES  1            wait cycles inserted per transfer (0..7)
// PORTS
//  clk_in        in   1   clock; all state changes on rising edge
//  rst_in        in   1   synchronous reset, active-high
//  hsel_in       in   1   slave select
//  haddr_in      in   32  byte address (address phase); bits [1:0] ignored
//  htrans_in     in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  hwrite_in     in   1   1 = write, 0 = read (address phase)
//  wr_mask_in    in   4   byte-lane write enables, lane i = hwdata[8i+7:8i] (data phase)
//  hwdata_in     in   32  write data, lanes pre-positioned by master (data phase)
//  hready_out    out  1   transfer complete / slave ready
//  hresp_out     out  1   0 OKAY, 1 ERROR
//  hrdata_out    out  32  read data, valid when hready_out=1 ending a read
// BEHAVIOUR
//  - Reset: hready_out=1, hresp_out=0, hrdata_out=0, FSM=IDLE, wait counter=0. RAM not cleared.
//  - Accept: address phase sampled when hsel_in & htrans_in[1] & hready_out. Registered haddr[*:2],
//    hwrite and range flag. BUSY/IDLE or hsel_in=0 -> no transfer, OKAY, hready_out stays 1.
//  - In range: BASE_ADDR <= haddr < BASE_ADDR + 4*2^DEPTH_LOG2; else ERROR path.
//  - FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
//    IDLE -> WAIT (accept, in range, WAIT_STATES>0); -> DATA (accept, in range, WAIT_STATES=0);
//    -> ERR1 (accept, out of range).
//    WAIT: hready_out=0, counter increments; at WAIT_STATES-1 -> DATA.
//    DATA: hready_out=1, OKAY. A write commits lanes where wr_mask_in[i]=1 at this edge;
//    a read drives hrdata_out = RAM[addr]. A new accept in the same cycle pipelines
//    (-> WAIT/DATA/ERR1); otherwise -> IDLE.
//    ERR1: hready_out=0, hresp_out=1 -> ERR2. ERR2: hready_out=1, hresp_out=1, no RAM write.
//    An accept in ERR2 pipelines as from DATA.
//  - Latency: a transfer completes WAIT_STATES+1 cycles after its address phase.
//  - hrdata_out is registered. It updates only on read completion and holds otherwise.
//  - Write then read of the same word back-to-back: the read returns the new data
//    (commit precedes the read's data phase).
//  - wr_mask_in=0000 on a write completes OKAY and leaves RAM unchanged.
//  - rst_in mid-transfer (WAIT/DATA/ERR*): transfer aborted, no write commits, outputs at reset values.
//  - hsel_in/htrans_in ignored while hready_out=0 (master must hold address phase).
// STRUCTURE
//  - Shared package riscv_ahb_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HRESP_OKAY/ERROR,
//    FSM state encoding.
//  - Sub-module dmem_bytelane_ram: 4 x 8-bit lanes, DEPTH_LOG2 address, per-lane write enable,
//    asynchronous read. The top holds the FSM, wait counter, decode and output registers.
// TESTING
//  1 Reset: rst_in=1 for 2 cycles -> hready_out=1, hresp_out=0, hrdata_out=0.
//  2 WAIT_STATES=1: word write 0xDEADBEEF mask 1111 @0x0001_0004, then read @0x0001_0004
//    -> hready_out low 1 cycle per transfer, hrdata_out=0xDEADBEEF.
//  3 Byte write 0x0000_AA00 mask 0010 over 0x11223344 -> read returns 0x1122AA44.
//  4 Out-of-range NONSEQ write @0x0000_0000 -> ERR1 (hready=0, hresp=1), ERR2 (hready=1,
//    hresp=1). RAM unchanged.
//  5 Back-to-back NONSEQ write then SEQ read, same word, WAIT_STATES=0 -> zero-wait,
//    read returns just-written data.
//  6 rst_in asserted during WAIT of a write -> no RAM update, next read returns the old value.

Source files
------------

// File: rtl/riscv_ahb_pkg.sv
// Shared AHB-Lite encodings and the data-memory responder state type.
package riscv_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } dmem_state_e;

    // Overlay the enabled byte lanes of new_w onto old_w.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  mask);
        logic [31:0] r;
        r = old_w;
        for (int unsigned i = 0; i < 4; i++) begin
            if (mask[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/ahb_dmem_slave_if.sv
// AHB-Lite bus bundle between the core's store/load master and the data-memory slave.
interface ahb_dmem_slave_if;

    logic        hsel_in;
    logic [31:0] haddr_in;
    logic [1:0]  htrans_in;
    logic        hwrite_in;
    logic [3:0]  wr_mask_in;
    logic [31:0] hwdata_in;
    logic        hready_out;
    logic        hresp_out;
    logic [31:0] hrdata_out;

    modport master (
        output hsel_in, haddr_in, htrans_in, hwrite_in, wr_mask_in, hwdata_in,
        input  hready_out, hresp_out, hrdata_out
    );

    modport slave (
        input  hsel_in, haddr_in, htrans_in, hwrite_in, wr_mask_in, hwdata_in,
        output hready_out, hresp_out, hrdata_out
    );

endinterface

// File: rtl/dmem_bytelane_ram.sv
// Word-addressed RAM built from four independent byte lanes; synchronous write, async read.
module dmem_bytelane_ram #(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic [3:0]            we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [31:0]           wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [31:0]           rdata_o
);

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem_q [2**DEPTH_LOG2];

        always_ff @(posedge clk_i) begin
            if (we_i[l]) mem_q[waddr_i] <= wdata_i[8*l +: 8];
        end

        assign rdata_o[8*l +: 8] = mem_q[raddr_i];
    end

endmodule

// File: rtl/ahb_dmem_slave.sv
// AHB-Lite data-memory responder: address decode, wait-state/error FSM and byte-lane RAM.
module ahb_dmem_slave
    import riscv_ahb_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input logic               clk_in,
    input logic               rst_in,
    ahb_dmem_slave_if.slave   bus
);

    localparam logic [32:0] RAM_BYTES = 33'(4) << DEPTH_LOG2;
    localparam logic [2:0]  WS_LAST   = 3'(WAIT_STATES - 1);

    dmem_state_e           state_q;
    dmem_state_e           issue_d;
    logic [2:0]            cnt_q;
    logic [DEPTH_LOG2-1:0] addr_q;
    logic                  write_q;
    logic                  hready_q;
    logic                  hresp_q;
    logic [31:0]           hrdata_q;

    logic [31:0]           offset;
    logic                  in_range;
    logic                  accept;
    logic [DEPTH_LOG2-1:0] haddr_idx;
    logic [DEPTH_LOG2-1:0] ram_raddr;
    logic [3:0]            ram_we;
    logic [31:0]           ram_rdata;
    logic [31:0]           rdata_fwd;

    assign offset    = bus.haddr_in - BASE_ADDR;
    assign in_range  = (bus.haddr_in >= BASE_ADDR) && ({1'b0, offset} < RAM_BYTES);
    assign haddr_idx = offset[DEPTH_LOG2+1:2];
    assign accept    = bus.hsel_in && hready_q &&
                       ((bus.htrans_in == HTRANS_NONSEQ) || (bus.htrans_in == HTRANS_SEQ));

    // Reset in the data phase must suppress the commit even though the RAM has no reset.
    assign ram_we    = (state_q == ST_DATA && write_q && !rst_in) ? bus.wr_mask_in : '0;
    assign ram_raddr = (state_q == ST_WAIT) ? addr_q : haddr_idx;

    // A zero-wait read pipelined behind a write to the same word sees the lanes committing now.
    assign rdata_fwd = (state_q == ST_DATA && write_q && addr_q == ram_raddr)
                     ? merge_lanes(ram_rdata, bus.hwdata_in, bus.wr_mask_in)
                     : ram_rdata;

    always_comb begin
        issue_d = ST_ERR1;
        if (in_range) issue_d = (WAIT_STATES == 0) ? ST_DATA : ST_WAIT;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
            hrdata_q <= '0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (cnt_q == WS_LAST) begin
                        state_q  <= ST_DATA;
                        cnt_q    <= '0;
                        hready_q <= 1'b1;
                        if (!write_q) hrdata_q <= rdata_fwd;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                ST_ERR1: begin
                    state_q  <= ST_ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_ERROR;
                end
                default: begin
                    if (accept) begin
                        state_q  <= issue_d;
                        addr_q   <= haddr_idx;
                        write_q  <= bus.hwrite_in;
                        cnt_q    <= '0;
                        hready_q <= (issue_d == ST_DATA);
                        hresp_q  <= (issue_d == ST_ERR1) ? HRESP_ERROR : HRESP_OKAY;
                        if (issue_d == ST_DATA && !bus.hwrite_in) hrdata_q <= rdata_fwd;
                    end else begin
                        state_q  <= ST_IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    dmem_bytelane_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk_i   (clk_in),
        .we_i    (ram_we),
        .waddr_i (addr_q),
        .wdata_i (bus.hwdata_in),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign bus.hready_out = hready_q;
    assign bus.hresp_out  = hresp_q;
    assign bus.hrdata_out = hrdata_q;

endmodule

// File: tb/tb_ahb_dmem_slave.sv
// Cycle-by-cycle vector bench for ahb_dmem_slave with one and zero wait states.
module tb_ahb_dmem_slave;

    localparam logic [1:0] ID  = 2'b00;
    localparam logic [1:0] BSY = 2'b01;
    localparam logic [1:0] NS  = 2'b10;
    localparam logic [1:0] SQ  = 2'b11;

    typedef struct {
        logic        rst;
        logic        hsel;
        logic [1:0]  trans;
        logic        write;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic        ready;
        logic        resp;
        logic [31:0] rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst1, rst0;
    int   n_checks = 0;
    int   n_pass   = 0;

    vec_t tab_ws1[$];
    vec_t tab_ws0[$];

    always #5 clk = ~clk;

    ahb_dmem_slave_if bus1();
    ahb_dmem_slave_if bus0();

    ahb_dmem_slave #(
        .DEPTH_LOG2  (10),
        .BASE_ADDR   (32'h0001_0000),
        .WAIT_STATES (1)
    ) u_ws1 (
        .clk_in (clk),
        .rst_in (rst1),
        .bus    (bus1.slave)
    );

    ahb_dmem_slave #(
        .DEPTH_LOG2  (10),
        .BASE_ADDR   (32'h0001_0000),
        .WAIT_STATES (0)
    ) u_ws0 (
        .clk_in (clk),
        .rst_in (rst0),
        .bus    (bus0.slave)
    );

    function automatic vec_t mk(input logic rst, input logic hsel, input logic [1:0] trans,
                                input logic write, input logic [31:0] addr,
                                input logic [3:0] mask, input logic [31:0] wdata,
                                input logic ready, input logic resp, input logic [31:0] rdata);
        vec_t v;
        v.rst = rst; v.hsel = hsel; v.trans = trans; v.write = write; v.addr = addr;
        v.mask = mask; v.wdata = wdata; v.ready = ready; v.resp = resp; v.rdata = rdata;
        return v;
    endfunction

    function automatic vec_t idle(input logic ready, input logic resp, input logic [31:0] rdata);
        return mk(1'b0, 1'b0, ID, 1'b0, 32'h0, 4'h0, 32'h0, ready, resp, rdata);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    endtask

    task automatic bus_idle1();
        bus1.hsel_in = 1'b0; bus1.haddr_in = '0; bus1.htrans_in = ID; bus1.hwrite_in = 1'b0;
        bus1.wr_mask_in = '0; bus1.hwdata_in = '0;
    endtask

    task automatic bus_idle0();
        bus0.hsel_in = 1'b0; bus0.haddr_in = '0; bus0.htrans_in = ID; bus0.hwrite_in = 1'b0;
        bus0.wr_mask_in = '0; bus0.hwdata_in = '0;
    endtask

    // One clock: drive inputs just after the rising edge, compare outputs on the falling edge.
    task automatic step(input vec_t v, input bit ws0, input string tag, input int idx);
        @(posedge clk);
        #1;
        if (ws0) begin
            bus_idle1();
            rst1 = 1'b0;
            rst0 = v.rst;
            bus0.hsel_in = v.hsel; bus0.haddr_in = v.addr; bus0.htrans_in = v.trans;
            bus0.hwrite_in = v.write; bus0.wr_mask_in = v.mask; bus0.hwdata_in = v.wdata;
        end else begin
            bus_idle0();
            rst0 = 1'b0;
            rst1 = v.rst;
            bus1.hsel_in = v.hsel; bus1.haddr_in = v.addr; bus1.htrans_in = v.trans;
            bus1.hwrite_in = v.write; bus1.wr_mask_in = v.mask; bus1.hwdata_in = v.wdata;
        end
        @(negedge clk);
        if (ws0) begin
            chk({tag, ".hready"}, idx, 32'(bus0.hready_out), 32'(v.ready));
            chk({tag, ".hresp"},  idx, 32'(bus0.hresp_out),  32'(v.resp));
            chk({tag, ".hrdata"}, idx, bus0.hrdata_out,      v.rdata);
        end else begin
            chk({tag, ".hready"}, idx, 32'(bus1.hready_out), 32'(v.ready));
            chk({tag, ".hresp"},  idx, 32'(bus1.hresp_out),  32'(v.resp));
            chk({tag, ".hrdata"}, idx, bus1.hrdata_out,      v.rdata);
        end
    endtask

    initial begin
        // One wait state: word write/read, byte merge, errors, no-transfer cycles, last word, empty mask.
        tab_ws1.push_back(mk(0, 1, NS, 1, 32'h0001_0004, 4'h0, 32'h0,          1, 0, 32'h0));
        tab_ws1.push_back(mk(0, 0, ID, 0, 32'h0,         4'hF, 32'hDEAD_BEEF,  0, 0, 32'h0));
        tab_ws1.push_back(mk(0, 1, NS, 0, 32'h0001_0004, 4'hF, 32'hDEAD_BEEF,  1, 0, 32'h0));
        tab_ws1.push_back(idle(0, 0, 32'h0));
        tab_ws1.push_back(idle(1, 0, 32'hDEAD_BEEF));
        tab_ws1.push_back(mk(0, 1, NS, 1, 32'h0001_0008, 4'h0, 32'h0,          1, 0, 32'hDEAD_BEEF));
        tab_ws1.push_back(mk(0, 0, ID, 0, 32'h0,         4'hF, 32'h1122_3344,  0, 0, 32'hDEAD_BEEF));
        tab_ws1.push_back(mk(0, 1, NS, 1, 32'h0001_0008, 4'hF, 32'h1122_3344,  1, 0, 32'hDEAD_BEEF));
        tab_ws1.push_back(mk(0, 0, ID, 0, 32'h0,         4'h2, 32'h0000_AA00,  0, 0, 32'hDEAD_BEEF));
        tab_ws1.push_back(mk(0, 1, NS, 0, 32'h0001_0008, 4'h2, 32'h0000_AA00,  1, 0, 32'hDEAD_BEEF));
        tab_ws1.push_back(idle(0, 0, 32'hDEAD_BEEF));
        tab_ws1.push_back(idle(1, 0, 32'h1122_AA44));
        tab_ws1.push_back(mk(0, 1, NS, 1, 32'h0000_0000, 4'h0, 32'h0,          1, 0, 32'h1122_AA44));
        tab_ws1.push_back(mk(0, 0, ID, 0, 32'h0,         4'hF, 32'hFFFF_FFFF,  0, 1, 32'h1122_AA44));
        tab_ws1.push_back(mk(0, 1, NS, 1, 32'h0001_1004, 4'hF, 32'hFFFF_FFFF,  1, 1, 32'h1122_AA44));
        tab_ws1.push_back(mk(0, 0, ID, 0, 32'h0,         4'hF, 32'hFFFF_FFFF,  0, 1, 32'h1122_AA44));
        tab_ws1.push_back(mk(0, 1, NS, 0, 32'h0001_0004, 4'hF, 32'hFFFF_FFFF,  1, 1, 32'h1122_AA44));
        tab_ws1.push_back(idle(0, 0, 32'h1122_AA44));
        tab_ws1.push_back(idle(1, 0, 32'hDEAD_BEEF));
        tab_ws1.push_back(mk(0, 1, BSY, 1, 32'h0001_0004, 4'h0, 32'h0,         1, 0, 32'hDEAD_BEEF));
        tab_ws1.push_back(mk(0, 0, NS, 1, 32'h0001_0004, 4'h0, 32'h0,          1, 0, 32'hDEAD_BEEF));
        tab_ws1.push_back(mk(0, 0, ID, 0, 32'h0,         4'hF, 32'h0,          1, 0, 32'hDEAD_BEEF));
        tab_ws1.push_back(mk(0, 1, NS, 1, 32'h0001_0FFC, 4'h0, 32'h0,          1, 0, 32'hDEAD_BEEF));
        tab_ws1.push_back(mk(0, 0, ID, 0, 32'h0,         4'hF, 32'hCAFE_F00D,  0, 0, 32'hDEAD_BEEF));
        tab_ws1.push_back(mk(0, 1, NS, 0, 32'h0001_0FFC, 4'hF, 32'hCAFE_F00D,  1, 0, 32'hDEAD_BEEF));
        tab_ws1.push_back(idle(0, 0, 32'hDEAD_BEEF));
        tab_ws1.push_back(idle(1, 0, 32'hCAFE_F00D));
        tab_ws1.push_back(mk(0, 1, NS, 1, 32'h0001_0004, 4'h0, 32'h0,          1, 0, 32'hCAFE_F00D));
        tab_ws1.push_back(mk(0, 0, ID, 0, 32'h0,         4'h0, 32'h1234_5678,  0, 0, 32'hCAFE_F00D));
        tab_ws1.push_back(mk(0, 1, NS, 0, 32'h0001_0004, 4'h0, 32'h1234_5678,  1, 0, 32'hCAFE_F00D));
        tab_ws1.push_back(idle(0, 0, 32'hCAFE_F00D));
        tab_ws1.push_back(idle(1, 0, 32'hDEAD_BEEF));

        // Zero wait states: write then SEQ read of the same word, full and partial masks, error.
        tab_ws0.push_back(mk(0, 1, NS, 1, 32'h0001_0010, 4'h0, 32'h0,          1, 0, 32'h0));
        tab_ws0.push_back(mk(0, 1, SQ, 0, 32'h0001_0010, 4'hF, 32'hA5A5_0F0F,  1, 0, 32'h0));
        tab_ws0.push_back(mk(0, 1, NS, 1, 32'h0001_0010, 4'h0, 32'h0,          1, 0, 32'hA5A5_0F0F));
        tab_ws0.push_back(mk(0, 1, SQ, 0, 32'h0001_0010, 4'h1, 32'h0000_00EE,  1, 0, 32'hA5A5_0F0F));
        tab_ws0.push_back(idle(1, 0, 32'hA5A5_0FEE));
        tab_ws0.push_back(mk(0, 1, NS, 0, 32'h0001_0010, 4'h0, 32'h0,          1, 0, 32'hA5A5_0FEE));
        tab_ws0.push_back(idle(1, 0, 32'hA5A5_0FEE));
        tab_ws0.push_back(mk(0, 1, NS, 0, 32'h0002_0000, 4'h0, 32'h0,          1, 0, 32'hA5A5_0FEE));
        tab_ws0.push_back(idle(0, 1, 32'hA5A5_0FEE));
        tab_ws0.push_back(idle(1, 1, 32'hA5A5_0FEE));
        tab_ws0.push_back(idle(1, 0, 32'hA5A5_0FEE));

        bus_idle1();
        bus_idle0();
        rst1 = 1'b1;
        rst0 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.ws1.hready", 0, 32'(bus1.hready_out), 32'd1);
        chk("rst.ws1.hresp",  0, 32'(bus1.hresp_out),  32'd0);
        chk("rst.ws1.hrdata", 0, bus1.hrdata_out,      32'h0);
        chk("rst.ws0.hready", 0, 32'(bus0.hready_out), 32'd1);
        chk("rst.ws0.hresp",  0, 32'(bus0.hresp_out),  32'd0);
        chk("rst.ws0.hrdata", 0, bus0.hrdata_out,      32'h0);

        for (int i = 0; i < tab_ws1.size(); i++) step(tab_ws1[i], 1'b0, "ws1", i);
        for (int i = 0; i < tab_ws0.size(); i++) step(tab_ws0[i], 1'b1, "ws0", i);

        // Reset during the wait state of a write: word 1 must keep 0xDEADBEEF.
        step(mk(0, 1, NS, 1, 32'h0001_0004, 4'h0, 32'h0,         1, 0, 32'hDEAD_BEEF), 1'b0, "rstw", 0);
        step(mk(1, 0, ID, 0, 32'h0,         4'hF, 32'h5555_5555, 0, 0, 32'hDEAD_BEEF), 1'b0, "rstw", 1);
        step(mk(0, 0, ID, 0, 32'h0,         4'hF, 32'h5555_5555, 1, 0, 32'h0),         1'b0, "rstw", 2);
        step(mk(0, 1, NS, 0, 32'h0001_0004, 4'h0, 32'h0,         1, 0, 32'h0),         1'b0, "rstw", 3);
        step(idle(0, 0, 32'h0),                                                         1'b0, "rstw", 4);
        step(idle(1, 0, 32'hDEAD_BEEF),                                                 1'b0, "rstw", 5);

        // Reset during the data phase of a write: the lanes must not commit.
        step(mk(0, 1, NS, 1, 32'h0001_0004, 4'h0, 32'h0,         1, 0, 32'hDEAD_BEEF), 1'b0, "rstd", 0);
        step(mk(0, 0, ID, 0, 32'h0,         4'hF, 32'h6666_6666, 0, 0, 32'hDEAD_BEEF), 1'b0, "rstd", 1);
        step(mk(1, 0, ID, 0, 32'h0,         4'hF, 32'h6666_6666, 1, 0, 32'hDEAD_BEEF), 1'b0, "rstd", 2);
        step(mk(0, 1, NS, 0, 32'h0001_0004, 4'h0, 32'h0,         1, 0, 32'h0),         1'b0, "rstd", 3);
        step(idle(0, 0, 32'h0),                                                         1'b0, "rstd", 4);
        step(idle(1, 0, 32'hDEAD_BEEF),                                                 1'b0, "rstd", 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
